// File: rtl/unpacker.sv
// Purpose  : fetch one 8-beat x 64-bit PSRAM burst (32 RGB565 words) into a local
//            4-bank x 8-entry buffer, then serve it one 16-bit word per pop.
// Latency  : i_start -> o_psram_read_req 1 cycle; last beat -> o_done 1 cycle;
//            i_data_read -> o_data/o_data_valid 1 cycle.
// Backpress: no stall on the PSRAM side, so beats are taken whenever valid in RECEIVING.
//            Pops are honoured only in READY and are dropped silently otherwise.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start, i_start_index         start a fetch (IDLE/READY only), first word to present
//   o_busy, o_done                 fetch in progress / one-cycle completion pulse
//   o_psram_read_req,
//   i_psram_read_gnt               burst request handshake with the PSRAM arbiter
//   i_psram_data_valid,
//   i_psram_data                   read beats; lane b carries word 4k+b
//   i_data_read, o_data,
//   o_data_valid                   downstream pop interface
module unpacker #(
  parameter int BURST_BEATS = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic [$clog2(4*BURST_BEATS)-1:0] i_start_index,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_psram_read_req,
  input  logic                             i_psram_read_gnt,
  input  logic                             i_psram_data_valid,
  input  logic [63:0]                      i_psram_data,
  input  logic                             i_data_read,
  output logic [15:0]                      o_data,
  output logic                             o_data_valid
);

  localparam int WORDS = 4 * BURST_BEATS;
  localparam int PW    = $clog2(WORDS);
  localparam int BW    = $clog2(BURST_BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_GNT,
    S_RECEIVING,
    S_READY
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   beat_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            req_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     data_q;
  logic            data_vld_q;

  // Word n is stored in bank n[1:0], entry n[PW-1:2], matching the write-side packer.
  logic [15:0]     mem_q [4][BURST_BEATS];

  logic            beat_wr;
  logic            beat_last;
  logic [15:0]     data_d;

  assign beat_wr   = (state_q == S_RECEIVING) && i_psram_data_valid;
  assign beat_last = (beat_q == BW'(BURST_BEATS - 1));
  assign data_d    = mem_q[rd_ptr_q[1:0]][rd_ptr_q[PW-1:2]];

  // Buffer storage carries no reset; it is always fully rewritten before READY.
  always_ff @(posedge i_clk) begin
    if (beat_wr) begin
      for (int b = 0; b < 4; b++) begin
        mem_q[b][beat_q] <= i_psram_data[16*b +: 16];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      rd_ptr_q   <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
    end else begin
      // Pulsed outputs default low; they are set only in the cycle they apply to.
      done_q     <= 1'b0;
      data_vld_q <= 1'b0;
      case (state_q)
        S_IDLE, S_READY: begin
          if (i_start) begin
            // Start takes priority over a simultaneous pop.
            state_q  <= S_WAIT_GNT;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            beat_q   <= '0;
            rd_ptr_q <= i_start_index;
          end else if ((state_q == S_READY) && i_data_read) begin
            data_q     <= data_d;
            data_vld_q <= 1'b1;
            rd_ptr_q   <= rd_ptr_q + 1'b1;
          end
        end
        S_WAIT_GNT: begin
          if (i_psram_read_gnt) begin
            state_q <= S_RECEIVING;
            req_q   <= 1'b0;
          end
        end
        S_RECEIVING: begin
          if (i_psram_data_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_last) begin
              state_q <= S_READY;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_psram_read_req = req_q;
  assign o_data           = data_q;
  assign o_data_valid     = data_vld_q;

endmodule

// File: doc/unpacker.md
Name: unpacker

Overview:
Read-side counterpart of the framebuffer line packer. On a start request it performs one PSRAM read burst of eight 64-bit beats (32 RGB565 pixels) into a local 4-bank × 8-entry buffer. It then serves those pixels one 16-bit word at a time to the HDMI scan-out path. Buffer word order matches the write side: word n lives in bank n[1:0], entry n[4:2].

Parameters:
BURST_BEATS, 8, 64-bit beats per burst (fixed; words = 4*BURST_BEATS = 32)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  begin new fetch; accepted only in IDLE or READY
i_start_index  input  5  first word index presented after fetch, sampled on accepted i_start
o_busy  output  1  high in WAIT_GNT and RECEIVING
o_done  output  1  one-cycle pulse when all 8 beats are stored
o_psram_read_req  output  1  burst read request
i_psram_read_gnt  input  1  arbiter grant
i_psram_data_valid  input  1  qualifies i_psram_data
i_psram_data  input  64  read beat; [15:0] = word 4k, [63:48] = word 4k+3
i_data_read  input  1  downstream pops one word
o_data  output  16  pixel word, registered
o_data_valid  output  1  high the cycle o_data updates from a pop

Behaviour:
- Reset: state IDLE. All outputs 0. Beat counter 0. Read pointer 0. Buffer contents undefined and need no reset.
- FSM states: IDLE, WAIT_GNT, RECEIVING, READY.
- IDLE / READY with i_start:
  - Next state WAIT_GNT; o_psram_read_req=1 from the next cycle.
  - Beat counter cleared; read pointer ← i_start_index.
- WAIT_GNT:
  - o_psram_read_req stays high until i_psram_read_gnt is sampled high.
  - On gnt: next state RECEIVING, req=0 next cycle.
  - i_psram_data_valid here is ignored.
- RECEIVING, each cycle with i_psram_data_valid:
  - Write bank b entry k ← i_psram_data[16b+15:16b], b = 0..3, k = beat counter.
  - Beat counter +1.
  - Beats may arrive with gaps; there is no timeout.
- On the cycle beat 7 is written: next state READY; o_done=1 for exactly the following cycle.
- READY: further i_psram_data_valid is ignored; the buffer is not overwritten.
- Readout, READY only, on i_data_read:
  - Next cycle: o_data = buffer word[read pointer], o_data_valid=1.
  - Read pointer +1, 5-bit wrap (31→0).
  - Without a pop: o_data_valid=0 and o_data holds its value.
- Pops in IDLE, WAIT_GNT or RECEIVING: ignored. Pointer and o_data unchanged, o_data_valid=0.
- i_start in WAIT_GNT or RECEIVING: ignored, no effect on the burst.
- i_start and i_data_read in the same READY cycle: start wins, pop ignored, o_data_valid=0.
- Re-reading after wrap returns the same data; the buffer persists until the next fetch completes.
- Reset asserted mid-burst: immediate return to IDLE, req drops asynchronously. Remaining beats after reset are ignored.
- Latency: i_start→req 1 cycle; last valid beat→o_done 1 cycle; pop→o_data 1 cycle.

Test Plan:
- Basic fetch:
  - Stimulus: start with index 0; gnt 3 cycles after req; 8 contiguous beats, beat k = {16'(4k+3),16'(4k+2),16'(4k+1),16'(4k)}.
  - Required: req high exactly until gnt+1; o_done one cycle after beat 7.
  - Then 32 back-to-back pops yield o_data 0..31, each valid one cycle after its pop.
- Gapped beats: valid asserted every 3rd cycle, plus one spurious valid during WAIT_GNT. Required: spurious beat not stored; o_done only after the 8th real beat; readout correct.
- Start index wrap: i_start_index=30, then 4 pops. Required: o_data = 30, 31, 0, 1.
- Busy protection:
  - i_start and pops during RECEIVING → ignored; o_busy=1; no second req; o_data_valid stays 0.
  - An extra valid beat in READY does not corrupt word 0.
- Start/pop collision: in READY assert i_start and i_data_read together. Required: o_data_valid=0, req next cycle, o_busy=1.
- Reset mid-burst:
  - Stimulus: assert i_rst_n low after beat 3.
  - Required: o_psram_read_req, o_busy, o_done, o_data_valid, o_data all 0; state IDLE.
  - A new fetch after release completes normally.
